// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU. It works on operand magnitudes and
// applies the sign fix-up at the end. It owns the HI (remainder) and LO (quotient) registers.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_ZERO = 2'd3
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_done;
    logic             r_dbz;

    logic                    w_dvd_neg;
    logic                    w_dvs_neg;
    logic [WIDTH-1:0]        w_dvd_mag;
    logic [WIDTH-1:0]        w_dvs_mag;
    logic [WIDTH:0]          w_rem_sh;
    logic signed [WIDTH:0]   w_trial;
    logic                    w_trial_ok;
    logic [WIDTH-1:0]        w_rem_nx;
    logic [WIDTH-1:0]        w_quo_nx;

    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    assign w_dvd_neg = is_signed & dividend[WIDTH-1];
    assign w_dvs_neg = is_signed & divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? f_neg(dividend) : dividend;
    assign w_dvs_mag = w_dvs_neg ? f_neg(divisor) : divisor;

    // The shifted remainder is below 2*|divisor|, so one extra bit is enough to hold the borrow.
    assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = $signed(w_rem_sh - {1'b0, r_dvs});
    assign w_trial_ok = ~w_trial[WIDTH];
    assign w_rem_nx   = w_trial_ok ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_nx   = {r_quo[WIDTH-2:0], w_trial_ok};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r <= w_dvd_neg;
                        r_rem   <= '0;
                        r_dvs   <= w_dvs_mag;
                        r_count <= CW'(WIDTH);
                        // The zero-divisor path keeps the raw dividend for HI.
                        if (divisor == '0) begin
                            r_quo   <= dividend;
                            r_state <= S_ZERO;
                        end else begin
                            r_quo   <= w_dvd_mag;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem   <= w_rem_nx;
                        r_quo   <= w_quo_nx;
                        r_count <= r_count - CW'(1);
                        if (r_count == CW'(1)) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        r_lo   <= r_neg_q ? f_neg(r_quo) : r_quo;
                        r_hi   <= r_neg_r ? f_neg(r_rem) : r_rem;
                        r_dbz  <= 1'b0;
                        r_done <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                S_ZERO: begin
                    if (!flush) begin
                        r_lo   <= '1;
                        r_hi   <= r_quo;
                        r_dbz  <= 1'b1;
                        r_done <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign lo          = r_lo;
    assign hi          = r_hi;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, signed/unsigned results, divide-by-zero,
// start/flush handshake and asynchronous reset.
module tb_div_unit;
    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         is_signed;
    logic         flush;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .lo          (lo),
        .hi          (hi),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called 1 time unit after a rising edge with the DUT idle. lat counts edges after the
    // accepting edge until done is seen; bcyc counts sampled cycles with busy high.
    task automatic do_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int bcyc);
        start = 1'b1; is_signed = s; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        bcyc = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcyc++;
        end
    endtask

    task automatic test_reset();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    endtask

    task automatic test_unsigned();
        int lat, bc;
        do_div(1'b0, 32'd100, 32'd7, lat, bc);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL udiv_latency: got %0d expected 33", lat); end
        n_checks++; if (bc !== 33) begin n_fail++; $display("FAIL udiv_busy_cycles: got %0d expected 33", bc); end
        n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL udiv_lo: got %h expected %h", lo, 32'd14); end
        n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL udiv_hi: got %h expected %h", hi, 32'd2); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL udiv_dbz: got %b expected 0", div_by_zero); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL udiv_done_pulse: got %b expected 0", done); end
        n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL udiv_lo_hold: got %h expected %h", lo, 32'd14); end
    endtask

    task automatic test_signed();
        int lat, bc;
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bc);
        n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL sdiv_m7_2_lo: got %h expected FFFFFFFD", lo); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sdiv_m7_2_hi: got %h expected FFFFFFFF", hi); end
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, lat, bc);
        n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL sdiv_7_m2_lo: got %h expected FFFFFFFD", lo); end
        n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL sdiv_7_m2_hi: got %h expected 00000001", hi); end
        do_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, lat, bc);
        n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL sdiv_m100_m7_lo: got %h expected 0000000E", lo); end
        n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sdiv_m100_m7_hi: got %h expected FFFFFFFE", hi); end
    endtask

    task automatic test_edge_operands();
        int lat, bc;
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
        n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_lo: got %h expected 80000000", lo); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL ovf_hi: got %h expected 00000000", hi); end
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, lat, bc);
        n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL umax_lo: got %h expected FFFFFFFF", lo); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL umax_hi: got %h expected 00000000", hi); end
        do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL ubig_lo: got %h expected 00000000", lo); end
        n_checks++; if (hi !== 32'h8000_0000) begin n_fail++; $display("FAIL ubig_hi: got %h expected 80000000", hi); end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        do_div(1'b0, 32'h1234_5678, 32'h0, lat, bc);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL dz_u_latency: got %0d expected 1", lat); end
        n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_u_lo: got %h expected FFFFFFFF", lo); end
        n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL dz_u_hi: got %h expected 12345678", hi); end
        n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_u_flag: got %b expected 1", div_by_zero); end
        do_div(1'b0, 32'd7, 32'd7, lat, bc);
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dz_clear_flag: got %b expected 0", div_by_zero); end
        n_checks++; if (lo !== 32'd1) begin n_fail++; $display("FAIL dz_clear_lo: got %h expected 00000001", lo); end
        do_div(1'b1, 32'h1234_5678, 32'h0, lat, bc);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL dz_s_latency: got %0d expected 1", lat); end
        n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL dz_s_hi: got %h expected 12345678", hi); end
        n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_s_flag: got %b expected 1", div_by_zero); end
        do_div(1'b1, 32'h8765_4321, 32'h0, lat, bc);
        n_checks++; if (hi !== 32'h8765_4321) begin n_fail++; $display("FAIL dz_sneg_hi: got %h expected 87654321", hi); end
        n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_sneg_lo: got %h expected FFFFFFFF", lo); end
    endtask

    task automatic test_handshake_flush();
        int lat, bc;
        logic seen_done;
        do_div(1'b0, 32'd100, 32'd7, lat, bc);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        seen_done = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 5) begin start = 1'b1; dividend = 32'd9; divisor = 32'd3; end
            if (i == 6) start = 1'b0;
            if (i == 10) flush = 1'b1;
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        flush = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", busy); end
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL flush_no_done: got %b expected 0", seen_done); end
        n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL flush_lo_hold: got %h expected 0000000E", lo); end
        n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL flush_hi_hold: got %h expected 00000002", hi); end

        // Restart, with an extra start while busy that must be ignored.
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            if (lat == 4) begin start = 1'b1; dividend = 32'd9; divisor = 32'd3; end
            if (lat == 5) start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL restart_latency: got %0d expected 33", lat); end
        n_checks++; if (lo !== 32'd10) begin n_fail++; $display("FAIL restart_lo: got %h expected 0000000A", lo); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL restart_hi: got %h expected 00000000", hi); end

        // flush together with start in IDLE drops the start.
        start = 1'b1; flush = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_flush_busy: got %b expected 0", busy); end

        // flush in FIX: no write.
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 32; i++) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        if (done) seen_done = 1'b1;
        @(posedge clk); #1;
        if (done) seen_done = 1'b1;
        n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL fix_flush_done: got %b expected 0", seen_done); end
        n_checks++; if (lo !== 32'd10) begin n_fail++; $display("FAIL fix_flush_lo: got %h expected 0000000A", lo); end

        // flush in ZERO: no write, flag unchanged.
        start = 1'b1; dividend = 32'h1234_5678; divisor = 32'h0;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_flush_done: got %b expected 0", done); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL zero_flush_dbz: got %b expected 0", div_by_zero); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL zero_flush_hi: got %h expected 00000000", hi); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        do_div(1'b0, 32'd20, 32'd4, lat, bc);
        n_checks++; if (lo !== 32'd5) begin n_fail++; $display("FAIL b2b_first_lo: got %h expected 00000005", lo); end
        // done is high now; the next start is presented in this very cycle.
        do_div(1'b0, 32'd9, 32'd2, lat, bc);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
        n_checks++; if (lo !== 32'd4) begin n_fail++; $display("FAIL b2b_lo: got %h expected 00000004", lo); end
        n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL b2b_hi: got %h expected 00000001", hi); end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        do_div(1'b0, 32'h1234_5678, 32'h0, lat, bc);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b expected 0", busy); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL arst_lo: got %h expected 00000000", lo); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL arst_hi: got %h expected 00000000", hi); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL arst_dbz: got %b expected 0", div_by_zero); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL arst_done: got %b expected 0", done); end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_div(1'b0, 32'd9, 32'd3, lat, bc);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL post_rst_latency: got %0d expected 33", lat); end
        n_checks++; if (lo !== 32'd3) begin n_fail++; $display("FAIL post_rst_lo: got %h expected 00000003", lo); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL post_rst_hi: got %h expected 00000000", hi); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; flush = 1'b0;
        dividend = '0; divisor = '0;
        #12;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_unsigned();
        test_signed();
        test_edge_operands();
        test_div_zero();
        test_handshake_flush();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
